episode_sequencer: RTL and testbench
====================================

Name: episode_sequencer

Overview:
Training-loop controller for the Q-learning maze datapath. It runs episodes on the 5x5 grid. Each step it selects an epsilon-greedy action, computes the next state, and hands {state, action, next_state, reward} to the Q-learning agent over a req/ack handshake. It ends an episode on goal, trap or step timeout, and stops after a fixed number of episodes. It sits above the agent, reward generator and maze map, and drives current_state for the whole datapath.

Parameters:
GRID_W, 5, grid side length; states are numbered 1..GRID_W*GRID_W in row-major order.
START_STATE, 1, state loaded at the start of every episode.
MAX_STEPS, 64, step limit per episode; reaching it ends the episode as a timeout.
MAX_EPISODES, 100, number of episodes in one training run.
LFSR_SEED, 16'hACE1, reset value of the exploration LFSR; must be non-zero.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; when low, all state is frozen
start  in  1  level-sampled; in IDLE or DONE, starts a new training run
epsilon  in  8  exploration threshold; P(random action) = epsilon/256
greedy_action  in  4  one-hot argmax action from the agent for cur_state
reward  in  16  signed reward from the reward generator for next_state
q_upd_ack  in  1  agent has consumed the update
cur_state  out  6  current grid state
action  out  4  one-hot chosen action: bit0 up, bit1 down, bit2 left, bit3 right
next_state  out  6  registered result of the move
q_upd_req  out  1  update request to the agent
goal  out  1  1-cycle pulse: episode ended at the goal state
error  out  1  1-cycle pulse: episode ended in a trap state
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE
step_cnt  out  8  steps taken in the current episode
episode_cnt  out  8  completed episodes in the current run

Behaviour:
- Reset values: FSM=IDLE; cur_state=START_STATE; next_state=START_STATE; action=0; all pulses, q_upd_req, done and counters=0; LFSR=LFSR_SEED.
- en=0: FSM, LFSR, counters and all outputs hold their values; a pending q_upd_req stays high; q_upd_ack is ignored.
- Goal state is GRID_W*GRID_W. Trap states are 3, 4, 7, 13, 14, 17, 19, 22.
- IDLE/DONE + start=1 -> INIT. INIT clears the counters and done, loads cur_state=START_STATE, then goes to SELECT.
- SELECT (1 cycle): the LFSR (x^16+x^14+x^13+x^11) advances once.
  - If lfsr[7:0] < epsilon, or greedy_action is not one-hot: action = one-hot(lfsr[9:8]).
  - Otherwise: action = greedy_action.
  - epsilon=0 with a one-hot greedy_action always takes the greedy action.
- MOVE (1 cycle): registers next_state. Row r = (s-1)/GRID_W, col c = (s-1)%GRID_W.
  - up: s-GRID_W if r>0; down: s+GRID_W if r<GRID_W-1; left: s-1 if c>0; right: s+1 if c<GRID_W-1.
  - At a wall the agent stays in place (next_state=cur_state).
  - Implementations may track row/col registers instead of dividing.
- UPDATE: q_upd_req=1, and cur_state/action/next_state/reward are held stable.
  - Leaves UPDATE on the first cycle with q_upd_ack=1; ack may arrive in the same cycle req rises.
  - q_upd_req is 0 from the following cycle.
  - No timeout; the FSM waits for ack indefinitely.
- CHECK (1 cycle): cur_state<=next_state; step_cnt+1 is computed.
  - Terminal cases, by priority: goal (goal pulse), then trap (error pulse), then step_cnt+1==MAX_STEPS (timeout, no pulse).
  - Terminal: episode_cnt++ and step_cnt<=0. If the new episode_cnt==MAX_EPISODES -> DONE; else cur_state<=START_STATE -> SELECT.
  - Non-terminal: step_cnt<=step_cnt+1 -> SELECT.
- Pulses are registered outputs and appear in the cycle after CHECK.
- Step latency without ack stall: 4 cycles (SELECT, MOVE, UPDATE, CHECK).
- Reset mid-UPDATE: q_upd_req drops asynchronously, and no update is counted.
- Counters saturate at 255. Parameter check: MAX_STEPS, MAX_EPISODES <= 255.

Decomposition:
- Package ql_pkg holds:
  - the state and action widths and one-hot action constants;
  - GOAL_STATE and the trap list, with an is_trap() function;
  - the FSM state enum {IDLE, INIT, SELECT, MOVE, UPDATE, CHECK, DONE}.
- The same package is reused by the reward generator and the top-level status logic.
- One sub-module: ql_lfsr16 (seeded 16-bit Galois LFSR with advance enable).
- Move logic and the FSM stay inline.

Test Plan:
- Reset, then idle with start=0 -> cur_state=1, busy=0, q_upd_req=0, counters=0, action=0.
- epsilon=0, greedy=right, ack tied high, START_STATE=1 -> steps 1->2->3; error pulses once; episode_cnt=1; cur_state returns to 1; q_upd_req high for 1 cycle per step.
- epsilon=0, greedy=down, MAX_STEPS=8 -> path 1,6,11,16,21, then held at 21 by the wall; the episode ends after 8 steps with no goal/error pulse; episode_cnt=1.
- START_STATE=20, greedy=down -> next_state=25; goal pulses 1 cycle; with MAX_EPISODES=1, done=1 and busy=0.
- ack withheld 5 cycles, en=0 for 3 cycles mid-UPDATE -> req, state, action and reward stay stable; exactly one update per step is counted.
- epsilon=255, fixed seed -> action always one-hot and equal to the reference LFSR model; rst_n asserted during UPDATE clears req immediately.

Source files
------------

// File: rtl/ql_pkg.sv
// Shared widths, action encodings, trap map and FSM states for the Q-learning maze datapath.
package ql_pkg;

    localparam int unsigned STATE_W        = 6;
    localparam int unsigned ACTION_W       = 4;
    localparam int unsigned REWARD_W       = 16;
    localparam int unsigned CNT_W          = 8;
    localparam int unsigned LFSR_W         = 16;
    localparam int unsigned RND_W          = 10;
    localparam int unsigned GRID_W_DEFAULT = 5;

    localparam logic [STATE_W-1:0] GOAL_STATE = STATE_W'(GRID_W_DEFAULT * GRID_W_DEFAULT);

    localparam logic [ACTION_W-1:0] ACT_UP    = 4'b0001;
    localparam logic [ACTION_W-1:0] ACT_DOWN  = 4'b0010;
    localparam logic [ACTION_W-1:0] ACT_LEFT  = 4'b0100;
    localparam logic [ACTION_W-1:0] ACT_RIGHT = 4'b1000;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SELECT,
        MOVE,
        UPDATE,
        CHECK,
        DONE
    } seq_state_e;

    function automatic logic is_trap(input logic [STATE_W-1:0] s);
        logic hit;
        case (s)
            6'd3, 6'd4, 6'd7, 6'd13, 6'd14, 6'd17, 6'd19, 6'd22: hit = 1'b1;
            default:                                              hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/episode_sequencer_if.sv
// Update channel between the sequencer, the Q-learning agent and the reward generator.
interface episode_sequencer_if;
    import ql_pkg::*;

    logic [STATE_W-1:0]  cur_state;
    logic [ACTION_W-1:0] action;
    logic [STATE_W-1:0]  next_state;
    logic                q_upd_req;
    logic                q_upd_ack;
    logic [ACTION_W-1:0] greedy_action;
    logic [REWARD_W-1:0] reward;

    // Sequencer side; reward flows from the reward generator straight to the agent.
    modport master (
        output cur_state, action, next_state, q_upd_req,
        input  greedy_action, q_upd_ack
    );

    modport slave (
        input  cur_state, action, next_state, q_upd_req, reward,
        output greedy_action, q_upd_ack
    );

    modport rwd (
        input  next_state,
        output reward
    );
endinterface

// File: rtl/ql_lfsr16.sv
// Seeded 16-bit Galois LFSR (x^16+x^14+x^13+x^11); steps once per cycle while adv is high.
module ql_lfsr16
    import ql_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    output logic [RND_W-1:0] value
);

    localparam logic [LFSR_W-1:0] TAPS = 16'hB400;

    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (adv) begin
            lfsr_q <= {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    assign value = lfsr_q[RND_W-1:0];

endmodule

// File: rtl/episode_sequencer.sv
// Training-loop controller: epsilon-greedy select, grid move, agent handshake, episode bookkeeping.
module episode_sequencer
    import ql_pkg::*;
#(
    parameter int unsigned       GRID_W       = 5,
    parameter int unsigned       START_STATE  = 1,
    parameter int unsigned       MAX_STEPS    = 64,
    parameter int unsigned       MAX_EPISODES = 100,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                start,
    input  logic [7:0]          epsilon,
    episode_sequencer_if.master bus,
    output logic                goal,
    output logic                error,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    step_cnt,
    output logic [CNT_W-1:0]    episode_cnt
);

    if (MAX_STEPS > 255 || MAX_EPISODES > 255 || LFSR_SEED == '0) begin : g_param_check
        $error("episode_sequencer: MAX_STEPS/MAX_EPISODES must be <= 255 and LFSR_SEED non-zero");
    end

    localparam logic [STATE_W-1:0] START = STATE_W'(START_STATE);
    localparam logic [STATE_W-1:0] GOAL  = STATE_W'(GRID_W * GRID_W);
    localparam logic [STATE_W-1:0] EDGE  = STATE_W'(GRID_W - 1);

    seq_state_e          state_q, state_d;
    logic [STATE_W-1:0]  cur_d, nxt_d, moved, s0, row, col;
    logic [ACTION_W-1:0] act_d, rand_act;
    logic [CNT_W-1:0]    step_d, ep_d, step_inc, ep_inc;
    logic                goal_d, error_d, lfsr_adv, greedy_ok, explore;
    logic [RND_W-1:0]    rnd;

    ql_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (lfsr_adv && en),
        .value (rnd)
    );

    // Action choice uses the LFSR value present in SELECT; it advances at the same edge.
    assign greedy_ok = (bus.greedy_action != '0) &&
                       ((bus.greedy_action & (bus.greedy_action - ACTION_W'(1))) == '0);
    assign explore   = (rnd[7:0] < epsilon) || !greedy_ok;
    assign rand_act  = ACTION_W'(1) << rnd[9:8];

    assign step_inc = (step_cnt == '1) ? step_cnt : step_cnt + CNT_W'(1);
    assign ep_inc   = (episode_cnt == '1) ? episode_cnt : episode_cnt + CNT_W'(1);

    assign s0  = bus.cur_state - STATE_W'(1);
    assign row = s0 / STATE_W'(GRID_W);
    assign col = s0 % STATE_W'(GRID_W);

    // Grid move; walls leave the agent in place.
    always_comb begin
        moved = bus.cur_state;
        case (bus.action)
            ACT_UP:    if (row != '0)   moved = bus.cur_state - STATE_W'(GRID_W);
            ACT_DOWN:  if (row != EDGE) moved = bus.cur_state + STATE_W'(GRID_W);
            ACT_LEFT:  if (col != '0)   moved = bus.cur_state - STATE_W'(1);
            ACT_RIGHT: if (col != EDGE) moved = bus.cur_state + STATE_W'(1);
            default:   moved = bus.cur_state;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = bus.cur_state;
        act_d    = bus.action;
        nxt_d    = bus.next_state;
        step_d   = step_cnt;
        ep_d     = episode_cnt;
        goal_d   = 1'b0;
        error_d  = 1'b0;
        lfsr_adv = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) state_d = INIT;
            INIT: begin
                step_d  = '0;
                ep_d    = '0;
                cur_d   = START;
                state_d = SELECT;
            end
            SELECT: begin
                lfsr_adv = 1'b1;
                act_d    = explore ? rand_act : bus.greedy_action;
                state_d  = MOVE;
            end
            MOVE: begin
                nxt_d   = moved;
                state_d = UPDATE;
            end
            UPDATE: if (bus.q_upd_ack) state_d = CHECK;
            CHECK: begin
                cur_d = bus.next_state;
                if (bus.next_state == GOAL || is_trap(bus.next_state) ||
                    step_inc == CNT_W'(MAX_STEPS)) begin
                    goal_d  = (bus.next_state == GOAL);
                    error_d = (bus.next_state != GOAL) && is_trap(bus.next_state);
                    ep_d    = ep_inc;
                    step_d  = '0;
                    if (ep_inc == CNT_W'(MAX_EPISODES)) begin
                        state_d = DONE;
                    end else begin
                        cur_d   = START;
                        state_d = SELECT;
                    end
                end else begin
                    step_d  = step_inc;
                    state_d = SELECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bus.cur_state  <= START;
            bus.next_state <= START;
            bus.action     <= '0;
            bus.q_upd_req  <= 1'b0;
            goal           <= 1'b0;
            error          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            step_cnt       <= '0;
            episode_cnt    <= '0;
        end else if (en) begin
            state_q        <= state_d;
            bus.cur_state  <= cur_d;
            bus.next_state <= nxt_d;
            bus.action     <= act_d;
            bus.q_upd_req  <= (state_d == UPDATE);
            goal           <= goal_d;
            error          <= error_d;
            busy           <= (state_d != IDLE) && (state_d != DONE);
            done           <= (state_d == DONE);
            step_cnt       <= step_d;
            episode_cnt    <= ep_d;
        end
    end

endmodule

// File: tb/tb_episode_sequencer.sv
// Directed bench for episode_sequencer: trap, timeout, goal/done, ack stall with enable, exploration.
module tb_episode_sequencer;
    import ql_pkg::*;

    logic       clk;
    logic       rst_a_n, rst_b_n, en_a, en_b, start_a, start_b;
    logic [7:0] eps_a, eps_b;
    logic       goal_a, error_a, busy_a, done_a;
    logic       goal_b, error_b, busy_b, done_b;
    logic [7:0] step_a, ep_a, step_b, ep_b;

    int checks = 0;
    int errors = 0;
    int upd_a = 0;
    int goal_cnt_a = 0;
    int err_cnt_a = 0;

    episode_sequencer_if bus_a ();
    episode_sequencer_if bus_b ();

    episode_sequencer dut_a (
        .clk         (clk),
        .rst_n       (rst_a_n),
        .en          (en_a),
        .start       (start_a),
        .epsilon     (eps_a),
        .bus         (bus_a),
        .goal        (goal_a),
        .error       (error_a),
        .busy        (busy_a),
        .done        (done_a),
        .step_cnt    (step_a),
        .episode_cnt (ep_a)
    );

    episode_sequencer #(.START_STATE(20), .MAX_STEPS(8), .MAX_EPISODES(1)) dut_b (
        .clk         (clk),
        .rst_n       (rst_b_n),
        .en          (en_b),
        .start       (start_b),
        .epsilon     (eps_b),
        .bus         (bus_b),
        .goal        (goal_b),
        .error       (error_b),
        .busy        (busy_b),
        .done        (done_b),
        .step_cnt    (step_b),
        .episode_cnt (ep_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes actually taken by dut_a, and pulses it emitted.
    always @(posedge clk) begin
        if (rst_a_n && en_a && bus_a.q_upd_req && bus_a.q_upd_ack) upd_a <= upd_a + 1;
    end
    always @(negedge clk) begin
        if (goal_a)  goal_cnt_a <= goal_cnt_a + 1;
        if (error_a) err_cnt_a  <= err_cnt_a + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a_n = 1'b0;
        tick();
        rst_a_n = 1'b1;
        tick();
    endtask

    task automatic wait_req_a(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus_a.q_upd_req && n < 40);
        chk({tag, " req"}, 32'(bus_a.q_upd_req), 1);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [3:0] exp_action(input logic [15:0] l, input logic [7:0] e,
                                              input logic [3:0] g);
        logic [3:0] one = 4'b0001;
        if (l[7:0] < e || !$onehot(g)) return one << l[9:8];
        return g;
    endfunction

    initial begin
        int n, u0, g0, e0;
        logic stable;
        logic [15:0] lfsr_m;
        logic [3:0] ea;

        rst_a_n = 1'b0; rst_b_n = 1'b0;
        en_a = 1'b1; en_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        eps_a = 8'd0; eps_b = 8'd0;
        bus_a.greedy_action = ACT_RIGHT; bus_a.q_upd_ack = 1'b1; bus_a.reward = 16'hFFF6;
        bus_b.greedy_action = ACT_DOWN;  bus_b.q_upd_ack = 1'b1; bus_b.reward = 16'h0064;
        tick(); tick();
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        tick(); tick();

        // Reset / idle
        chk("rst cur",    32'(bus_a.cur_state), 1);
        chk("rst next",   32'(bus_a.next_state), 1);
        chk("rst action", 32'(bus_a.action), 0);
        chk("rst req",    32'(bus_a.q_upd_req), 0);
        chk("rst busy",   32'(busy_a), 0);
        chk("rst done",   32'(done_a), 0);
        chk("rst steps",  32'(step_a), 0);
        chk("rst eps",    32'(ep_a), 0);
        chk("rst b cur",  32'(bus_b.cur_state), 20);
        chk("rst b next", 32'(bus_b.next_state), 20);

        // Greedy right from 1 into trap 3
        e0 = err_cnt_a;
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("trap busy", 32'(busy_a), 1);
        wait_req_a("trap s0");
        chk("trap s0 cur",  32'(bus_a.cur_state), 1);
        chk("trap s0 act",  32'(bus_a.action), 32'(ACT_RIGHT));
        chk("trap s0 next", 32'(bus_a.next_state), 2);
        tick();
        chk("trap req 1cyc", 32'(bus_a.q_upd_req), 0);
        wait_req_a("trap s1");
        chk("trap s1 cur",  32'(bus_a.cur_state), 2);
        chk("trap s1 next", 32'(bus_a.next_state), 3);
        chk("trap s1 step", 32'(step_a), 1);
        tick(); tick();
        chk("trap error", 32'(error_a), 1);
        chk("trap goal",  32'(goal_a), 0);
        chk("trap ep",    32'(ep_a), 1);
        chk("trap step",  32'(step_a), 0);
        chk("trap cur",   32'(bus_a.cur_state), 1);
        tick();
        chk("trap error pulse", 32'(error_a), 0);
        chk("trap error count", 32'(err_cnt_a - e0), 1);

        // Greedy down: 1,6,11,16,21 then wall until the 64-step timeout
        reset_a();
        bus_a.greedy_action = ACT_DOWN;
        g0 = goal_cnt_a; e0 = err_cnt_a;
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int k = 0; k < 64; k++) begin
            wait_req_a("timeout");
            if (k < 6) chk($sformatf("down next %0d", k), 32'(bus_a.next_state),
                           (k < 4) ? 32'(6 + 5 * k) : 32'd21);
            if (k == 63) chk("timeout last step", 32'(step_a), 63);
        end
        tick(); tick();
        chk("timeout ep",   32'(ep_a), 1);
        chk("timeout step", 32'(step_a), 0);
        chk("timeout cur",  32'(bus_a.cur_state), 1);
        tick();
        chk("timeout no pulse", 32'((goal_cnt_a - g0) + (err_cnt_a - e0)), 0);

        // Goal from 20 with a single-episode run
        start_b = 1'b1; tick(); start_b = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus_b.q_upd_req && n < 20);
        chk("goal req",  32'(bus_b.q_upd_req), 1);
        chk("goal cur",  32'(bus_b.cur_state), 20);
        chk("goal act",  32'(bus_b.action), 32'(ACT_DOWN));
        chk("goal next", 32'(bus_b.next_state), 25);
        tick(); tick();
        chk("goal pulse", 32'(goal_b), 1);
        chk("goal err",   32'(error_b), 0);
        chk("goal done",  32'(done_b), 1);
        chk("goal busy",  32'(busy_b), 0);
        chk("goal ep",    32'(ep_b), 1);
        tick();
        chk("goal pulse end", 32'(goal_b), 0);
        chk("goal done hold", 32'(done_b), 1);
        start_b = 1'b1; tick();
        chk("restart done", 32'(done_b), 0);
        chk("restart busy", 32'(busy_b), 1);
        tick(); start_b = 1'b0;
        chk("restart ep",  32'(ep_b), 0);
        chk("restart cur", 32'(bus_b.cur_state), 20);

        // Ack stall, then enable low with ack high, then reset mid-UPDATE
        bus_a.greedy_action = ACT_RIGHT; bus_a.q_upd_ack = 1'b0;
        reset_a();
        u0 = upd_a;
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_req_a("stall");
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            stable &= bus_a.q_upd_req && bus_a.cur_state == 6'd1 &&
                      bus_a.action == ACT_RIGHT && bus_a.next_state == 6'd2;
        end
        chk("stall hold", 32'(stable), 1);
        chk("stall no upd", 32'(upd_a - u0), 0);
        en_a = 1'b0; bus_a.q_upd_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            stable &= bus_a.q_upd_req && bus_a.cur_state == 6'd1 &&
                      bus_a.action == ACT_RIGHT && bus_a.next_state == 6'd2;
        end
        chk("en0 hold", 32'(stable), 1);
        chk("en0 ack ignored", 32'(upd_a - u0), 0);
        chk("en0 step", 32'(step_a), 0);
        en_a = 1'b1;
        tick();
        chk("ack req drop", 32'(bus_a.q_upd_req), 0);
        chk("ack one upd",  32'(upd_a - u0), 1);
        bus_a.q_upd_ack = 1'b0;
        tick();
        chk("stall cur",  32'(bus_a.cur_state), 2);
        chk("stall step", 32'(step_a), 1);
        wait_req_a("stall s1");
        chk("stall s1 next", 32'(bus_a.next_state), 3);
        #2 rst_a_n = 1'b0;
        #1;
        chk("async rst req",  32'(bus_a.q_upd_req), 0);
        chk("async rst cur",  32'(bus_a.cur_state), 1);
        chk("async rst step", 32'(step_a), 0);
        chk("async rst upd",  32'(upd_a - u0), 1);
        tick();
        rst_a_n = 1'b1;
        tick();

        // Exploration against the reference LFSR
        bus_a.q_upd_ack = 1'b1; bus_a.greedy_action = ACT_UP; eps_a = 8'd255;
        lfsr_m = 16'hACE1;
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            ea = exp_action(lfsr_m, eps_a, bus_a.greedy_action);
            lfsr_m = lfsr_next(lfsr_m);
            wait_req_a("explore");
            chk($sformatf("explore act %0d", k), 32'(bus_a.action), 32'(ea));
            chk($sformatf("explore onehot %0d", k), 32'($onehot(bus_a.action)), 1);
            if (k == 0) chk("explore hand 0", 32'(bus_a.action), 32'h1);
            if (k == 1) chk("explore hand 1", 32'(bus_a.action), 32'h4);
            if (k == 5) begin
                eps_a = 8'd0;
                bus_a.greedy_action = 4'b0000;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
